// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: one single-port 16-bit RAM shared between CPU bus
// accesses and a raster-order scanout prefetcher that feeds a pixel FIFO.
// Scanout wins while the FIFO runs low; the CPU gets every other free slot.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        frame_start,
  input  logic        pix_pop,
  output logic [11:0] pix_data,
  output logic        pix_underflow,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0] LOW_C   = (CW+1)'(LOW_WM);
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d;
  logic            cpu_rd_q, cpu_rd_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic            fetch_active_q, fetch_active_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [11:0]     head_q, head_d;
  logic            underflow_q, underflow_d;
  logic [11:0]     fifo_q [FIFO_DEPTH];

  logic [CW:0]     occ;
  logic            scan_want, cpu_want, grant_scan, grant_cpu;
  logic            push, pop_ok;

  // Bits of the bus words the RAM interface does not carry.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[31:20], cpu_addr[0], cpu_din[31:16]};

  // Slot arbitration; run_q holds off all grants until the first edge after reset.
  always_comb begin
    occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    scan_want  = run_q & fetch_active_q & ~frame_start & (occ < DEPTH_C);
    cpu_want   = run_q & cpu_sel & (state_q == IDLE);
    grant_scan = scan_want & ((occ < LOW_C) | ~cpu_want);
    grant_cpu  = cpu_want & ~grant_scan;
  end

  // RAM port and CPU response outputs.
  always_comb begin
    mem_en    = grant_scan | grant_cpu;
    mem_we    = grant_cpu & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_addr = cpu_addr[19:1];
      if (cpu_we) mem_wdata = cpu_din[15:0];
    end else if (grant_scan) begin
      mem_addr = {x_q, y_q};
    end
    cpu_ready     = (state_q == BUSY);
    cpu_rdata     = (state_q == BUSY && cpu_rd_q) ? {16'h0000, mem_rdata} : 32'h0;
    pix_data      = head_q;
    pix_underflow = underflow_q;
  end

  // CPU handshake FSM: one grant cycle, then one ready cycle.
  always_comb begin
    state_d  = state_q;
    cpu_rd_d = cpu_rd_q;
    run_d    = 1'b1;
    case (state_q)
      IDLE: if (grant_cpu) begin
        state_d  = BUSY;
        cpu_rd_d = ~cpu_we;
      end
      BUSY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster fetch counters; frame_start restarts the frame from (0,0).
  always_comb begin
    x_d            = x_q;
    y_d            = y_q;
    fetch_active_d = fetch_active_q;
    inflight_d     = grant_scan;
    if (frame_start) begin
      x_d            = '0;
      y_d            = '0;
      fetch_active_d = 1'b1;
    end else if (grant_scan) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d            = '0;
          fetch_active_d = 1'b0;
        end else begin
          y_d = y_q + 9'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Pixel FIFO bookkeeping; the read returning in a frame_start cycle is dropped.
  always_comb begin
    push        = inflight_q & ~frame_start;
    pop_ok      = pix_pop & (count_q != '0);
    underflow_d = underflow_q | (pix_pop & (count_q == '0));
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_d      = '0;
    if (frame_start) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop_ok);
      if (count_d == '0)
        head_d = '0;
      else if (push && rd_ptr_d == wr_ptr_q)
        head_d = mem_rdata[11:0];
      else
        head_d = fifo_q[rd_ptr_d];
    end
  end

  // FIFO storage, written on push only.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata[11:0];
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      run_q          <= 1'b0;
      cpu_rd_q       <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      fetch_active_q <= 1'b0;
      inflight_q     <= 1'b0;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      head_q         <= '0;
      underflow_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      cpu_rd_q       <= cpu_rd_d;
      x_q            <= x_d;
      y_q            <= y_d;
      fetch_active_q <= fetch_active_d;
      inflight_q     <= inflight_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      head_q         <= head_d;
      underflow_q    <= underflow_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a small frame geometry.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int H = 40;
  localparam int V = 6;
  localparam int TOTAL = H * V;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_sel, cpu_we;
  logic [31:0] cpu_addr, cpu_din;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        frame_start, pix_pop;
  logic [11:0] pix_data;
  logic        pix_underflow;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16), .LOW_WM(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .frame_start(frame_start), .pix_pop(pix_pop), .pix_data(pix_data),
    .pix_underflow(pix_underflow),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // RAM model: unwritten words read back as addr[15:0].
  logic [15:0] ram [int];

  function automatic logic [15:0] ram_rd(input logic [18:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return a[15:0];
  endfunction

  always @(posedge clock) begin
    if (mem_en && mem_we) ram[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram_rd(mem_addr);
    else mem_rdata <= 16'hDEAD;
  end

  // Scoreboards.
  logic [18:0] exp_addr_q [$];
  logic [11:0] exp_pix_q [$];
  logic [31:0] exp_rd_q [$];
  bit          scan_mon = 1'b0;
  int          scan_reads = 0;

  task automatic load_frame();
    logic [18:0] a;
    logic [15:0] d;
    exp_addr_q.delete();
    exp_pix_q.delete();
    scan_reads = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        a = {10'(x), 9'(y)};
        d = ram_rd(a);
        exp_addr_q.push_back(a);
        exp_pix_q.push_back(d[11:0]);
      end
    end
  endtask

  // Scan-read monitor: every scan read is compared against raster order.
  always begin
    @(negedge clock);
    #2;
    if (scan_mon && mem_en && !mem_we) begin
      scan_reads++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scan_extra_read: addr 0x%0h, no read expected", mem_addr);
      end else begin
        chk("scan_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  task automatic pulse_fs();
    @(negedge clock);
    frame_start = 1'b1;
    load_frame();
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  // Pop one pixel in the current cycle and compare it with the expected head.
  task automatic pop_chk(input string nm);
    pix_pop = 1'b1;
    #1;
    if (exp_pix_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: popped 0x%0h, no pixel expected", nm, pix_data);
    end else begin
      chk(nm, 32'(pix_data), 32'(exp_pix_q.pop_front()));
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [18:0] exp_ma;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic cpu_xfer(input vec_t v, input int idx);
    int wait_c;
    @(negedge clock);
    cpu_sel  = 1'b1;
    cpu_we   = v.we;
    cpu_addr = v.addr;
    cpu_din  = v.din;
    if (!v.we) exp_rd_q.push_back(v.exp_rd);
    #1;
    chk($sformatf("v%0d_grant", idx), 32'({mem_en, mem_we}), 32'({1'b1, v.we}));
    chk($sformatf("v%0d_addr", idx), 32'(mem_addr), 32'(v.exp_ma));
    if (v.we) chk($sformatf("v%0d_wdata", idx), 32'(mem_wdata), 32'(v.din[15:0]));
    wait_c = 0;
    do begin
      @(negedge clock);
      #1;
      wait_c++;
    end while (!cpu_ready && wait_c < 20);
    chk($sformatf("v%0d_ready_lat", idx), 32'(wait_c), 32'd1);
    if (cpu_ready && !v.we)
      chk($sformatf("v%0d_rdata", idx), cpu_rdata, exp_rd_q.pop_front());
    cpu_sel = 1'b0;
    @(negedge clock);
    #1;
    chk($sformatf("v%0d_ready_once", idx), 32'({cpu_ready, mem_en}), 32'd0);
  endtask

  initial begin
    int cnt, grant_at, ready_at, busy_en;

    vecs[0] = '{1'b0, 32'h0000_0402, 32'h0,         19'h00201, 32'h0000_ABCD};
    vecs[1] = '{1'b1, 32'h0008_1000, 32'hFFFF_1234, 19'h40800, 32'h0};
    vecs[2] = '{1'b0, 32'h0008_1000, 32'h0,         19'h40800, 32'h0000_1234};
    vecs[3] = '{1'b0, 32'h000F_FFFE, 32'h0,         19'h7FFFF, 32'h0000_FFFF};
    vecs[4] = '{1'b1, 32'h0000_0003, 32'h0000_5555, 19'h00001, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0002, 32'h0,         19'h00001, 32'h0000_5555};

    // Reset held with a pending CPU write.
    reset = 1'b0; cpu_sel = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h0000_0402; cpu_din = 32'h0000_ABCD;
    frame_start = 1'b0; pix_pop = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu", 32'(cpu_ready) | cpu_rdata, 32'd0);
    chk("rst_pix", 32'({pix_underflow, pix_data}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("release_no_grant", 32'(mem_en), 32'd0);
    @(negedge clock);
    #1;
    chk("first_grant", 32'({mem_en, mem_we}), 32'd3);
    chk("first_addr", 32'(mem_addr), 32'h201);
    chk("first_wdata", 32'(mem_wdata), 32'hABCD);
    chk("first_not_ready", 32'(cpu_ready), 32'd0);
    @(negedge clock);
    #1;
    chk("first_ready", 32'(cpu_ready), 32'd1);
    cpu_sel = 1'b0;
    @(negedge clock);
    #1;
    chk("first_ready_once", 32'({cpu_ready, mem_en}), 32'd0);

    // Table-driven CPU accesses with scanout idle.
    for (int i = 0; i < 6; i++) cpu_xfer(vecs[i], i);

    // Scan fill without pops: exactly one FIFO's worth of reads.
    ram.delete();
    scan_mon = 1'b1;
    pulse_fs();
    repeat (40) @(negedge clock);
    #1;
    chk("fill_reads", 32'(scan_reads), 32'd16);
    chk("fill_idle", 32'(mem_en), 32'd0);
    chk("fill_head", 32'(pix_data), 32'(exp_pix_q[0]));

    // Priority: CPU held from the cycle after frame_start waits for occ to reach 4.
    pulse_fs();
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_9000; cpu_din = 32'h0000_7777;
    cnt = 0; grant_at = -1; ready_at = -1;
    while (cnt < 30 && ready_at < 0) begin
      #1;
      if (mem_en && mem_we && grant_at < 0) begin
        grant_at = cnt;
        chk("prio_addr", 32'(mem_addr), 32'h0C800);
      end
      if (cpu_ready) ready_at = cnt;
      else begin
        @(negedge clock);
        cnt++;
      end
    end
    cpu_sel = 1'b0;
    chk("prio_grant_cycle", 32'(grant_at), 32'd4);
    chk("prio_ready_cycle", 32'(ready_at), 32'd5);

    // Full frame with one pop per cycle once the FIFO is primed.
    repeat (30) @(negedge clock);
    for (int i = 0; i < TOTAL; i++) begin
      @(negedge clock);
      pop_chk("frame_pix");
    end
    @(negedge clock);
    pix_pop = 1'b0;
    #1;
    chk("frame_empty", 32'(pix_data), 32'd0);
    chk("frame_no_underflow", 32'(pix_underflow), 32'd0);
    busy_en = 0;
    repeat (10) begin
      @(negedge clock);
      #1;
      if (mem_en) busy_en++;
    end
    chk("fetch_stopped", 32'(busy_en), 32'd0);
    chk("frame_reads", 32'(scan_reads), 32'(TOTAL));
    chk("frame_addr_drained", 32'(exp_addr_q.size()), 32'd0);

    // Mid-frame restart discards the in-flight read.
    pulse_fs();
    repeat (2) @(negedge clock);
    @(negedge clock);
    frame_start = 1'b1;
    load_frame();
    #1;
    chk("restart_no_grant", 32'(mem_en), 32'd0);
    @(negedge clock);
    frame_start = 1'b0;
    pix_pop = 1'b1;
    #1;
    chk("restart_empty", 32'(pix_data), 32'd0);
    @(negedge clock);
    pix_pop = 1'b0;
    #1;
    chk("underflow_set", 32'(pix_underflow), 32'd1);
    repeat (30) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      pop_chk("restart_pix");
    end
    @(negedge clock);
    pix_pop = 1'b0;
    #1;
    chk("underflow_sticky", 32'(pix_underflow), 32'd1);
    pulse_fs();
    #1;
    chk("underflow_after_fs", 32'(pix_underflow), 32'd1);

    // Asynchronous reset clears the sticky flag immediately.
    scan_mon = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("reset_clears", 32'({pix_underflow, pix_data, mem_en}), 32'd0);
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port, 16-bit-wide framebuffer RAM between the CPU bus and the VGA scanout path. The scanout path prefetches pixels in raster order into a small FIFO that the VGA timing logic pops. CPU reads and writes are granted in the slots scanout does not need. The block sits between the bus decoder / VGA timing generator and the framebuffer RAM. The RAM has 1-cycle read latency; its word address is {x[9:0], y[8:0]}.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
LOW_WM, 4, FIFO occupancy below which scanout has priority

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_sel  in  1  CPU request; held until cpu_ready
cpu_we  in  1  1=write, 0=read
cpu_addr  in  32  byte address; word index = cpu_addr[19:1]
cpu_din  in  32  write data; bits [15:0] used
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  32  {16'b0, word}; valid when cpu_ready=1 and the request is a read
frame_start  in  1  pulse at start of vertical blank
pix_pop  in  1  consume one pixel
pix_data  out  12  FIFO head, bits [11:0] of the word; 0 if empty
pix_underflow  out  1  sticky; pix_pop while FIFO empty
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write
mem_addr  out  19  RAM word address
mem_wdata  out  16  RAM write data
mem_rdata  in  16  RAM read data, 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - FIFO empty; fetch counters x=y=0; fetch_active=0.
  - FSM = IDLE; no read in flight.
- Slot accounting: at most one RAM access per cycle. occ = FIFO count + scan reads in flight (0/1).
- scan_want = fetch_active AND occ < FIFO_DEPTH.
- cpu_want = cpu_sel AND FSM=IDLE.
- Grant rules, evaluated each cycle:
  1. scan_want and occ < LOW_WM -> scan.
  2. else cpu_want -> cpu.
  3. else scan_want -> scan.
  4. else no access (mem_en=0).
- Scan grant:
  - mem_en=1, mem_we=0, mem_addr={x, y[8:0]}.
  - x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments.
  - Granting (H_ACTIVE-1, V_ACTIVE-1) clears fetch_active.
  - Data is pushed into the FIFO the next cycle.
- CPU grant (FSM IDLE -> BUSY):
  - mem_en=1, mem_addr=cpu_addr[19:1].
  - Write: mem_we=1, mem_wdata=cpu_din[15:0].
  - Next cycle (BUSY): cpu_ready=1 for exactly one cycle. For a read, cpu_rdata={16'b0, mem_rdata}.
  - Then BUSY -> IDLE unconditionally. A still-asserted cpu_sel in the IDLE cycle after ready is treated as a new request.
  - Scan may be granted during BUSY.
  - CPU latency: 2 cycles minimum from cpu_sel rising; unbounded only while occ < LOW_WM.
- FIFO pop:
  - pix_data is the registered FIFO head.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop when empty: count stays 0, pix_data=0, pix_underflow set. Only reset clears pix_underflow.
- frame_start, highest precedence:
  - Flushes the FIFO and sets x=y=0, fetch_active=1.
  - Marks any in-flight scan read as discard; its data is not pushed.
  - No scan grant in the frame_start cycle.
  - A CPU access in flight completes normally.
  - frame_start while fetch_active=1 restarts the frame.
- Pushes never exceed FIFO_DEPTH; this is guaranteed by occ gating.
- Full: no scan grant; all slots are available to the CPU.

Test Plan:
- Reset: hold reset=0 with cpu_sel=1 -> all outputs 0; after release, first CPU write grant 1 cycle later; cpu_ready pulse 2 cycles after cpu_sel.
- CPU write/read: write cpu_addr=0x0000_0402, din=0xABCD, with fetch idle -> mem_addr=0x00201, mem_wdata=0xABCD; a following read returns cpu_rdata=0x0000_ABCD with a single ready pulse.
- Scan fill: frame_start, no pops, RAM model returns addr[15:0] -> 16 reads, addresses {0,0},{1,0},...,{15,0}; then mem_en idle; occ never exceeds 16.
- Priority: FIFO at 3 entries, cpu_sel held -> scan granted first until occ=4; CPU granted at the next slot; cpu_ready one cycle later.
- Wrap/end: run a full frame with 1 pop/cycle -> address after {639,0} is {0,1}; last fetch {639,479}; fetch_active drops; exactly 307200 pushes; pix_underflow stays 0.
- Mid-frame restart: frame_start asserted the cycle after a scan grant -> that read is discarded, FIFO empty, next scan address {0,0}; a popped-empty pixel sets pix_underflow=1, which persists until reset.
